addersub_wb_stage: RTL and testbench

Registered result stage directly downstream of the scalar add/sub/set-less-than unit. Each cycle it accepts that unit's WIDTH-bit sum, its set-less-than bit and the instruction's operation code and destination register. It forms the final register-file write value and write enable, and holds them in a two-entry skid buffer behind a valid/ready handshake. This lets a writeback-side stall back-pressure the execute stage without a combinational ready path.

---
 rtl/addersub_wb_stage_pkg.sv | 42 ++++
 rtl/addersub_wb_skid.sv | 100 ++++++++++
 rtl/addersub_wb_stage.sv | 88 ++++++++
 tb/tb_addersub_wb_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/addersub_wb_stage_pkg.sv
// addersub_wb_stage_pkg: shared constants, entry layout and overflow helper
// for the add/sub/slt writeback stage.
// Optional feature macro: ADDERSUB_OVF_TRAP_EN (signed-overflow trap).
package addersub_wb_stage_pkg;

  localparam int WB_WIDTH = 32;
  localparam int WB_REGW  = 5;

  // Operation codes presented by the adder.
  localparam logic [2:0] OP_SUBU = 3'd0;
  localparam logic [2:0] OP_ADDU = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SLTU = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd6;

  // Bit positions inside the operation code.
  localparam int IS_SLT  = 2;
  localparam int SIGNEXT = 1;
  localparam int ADDSUB  = 0;

  // One buffered writeback entry.
  typedef struct packed {
    logic [WB_WIDTH-1:0] data;
    logic [WB_REGW-1:0]  dst;
    logic                we;
    logic                ovf;
  } wb_entry_t;

  // Signed overflow from operand and result sign bits; only ADD and SUB trap.
  function automatic logic add_sub_ovf(input logic [2:0] op, input logic a_msb,
                                       input logic b_msb, input logic r_msb);
    logic v;
    case (op)
      OP_ADD:  v = (a_msb == b_msb) & (r_msb != a_msb);
      OP_SUB:  v = (a_msb != b_msb) & (r_msb != a_msb);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/addersub_wb_skid.sv
// addersub_wb_skid: generic two-entry valid/ready skid buffer. Outputs come
// straight from the main register, and in_ready is a register, so neither
// side sees a combinational path from the other. Main data is zeroed
// whenever the main entry is empty.
module addersub_wb_skid
  #(parameter int W = 8)
  (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
  );

  // Buffer state encoded as {main_v, skid_v}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic         r_main_v, r_skid_v, r_in_ready;
  logic [W-1:0] r_main_d, r_skid_d;
  logic         w_main_v, w_skid_v;
  logic [W-1:0] w_main_d, w_skid_d;
  logic         w_accept, w_emit;

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_main_v & out_ready;

  // Next-state of both entries from accept/emit in the current state.
  always_comb begin
    w_main_v = r_main_v;
    w_skid_v = r_skid_v;
    w_main_d = r_main_d;
    w_skid_d = r_skid_d;
    case ({r_main_v, r_skid_v})
      ST_EMPTY: begin
        if (w_accept) begin
          w_main_v = 1'b1;
          w_main_d = in_data;
        end else begin
          w_main_d = {W{1'b0}};
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_main_d = in_data;
        end else if (w_accept) begin
          w_skid_v = 1'b1;
          w_skid_d = in_data;
        end else if (w_emit) begin
          w_main_v = 1'b0;
          w_main_d = {W{1'b0}};
        end else begin
          w_main_d = r_main_d;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only an emit can happen.
        if (w_emit) begin
          w_main_d = r_skid_d;
          w_skid_v = 1'b0;
          w_skid_d = {W{1'b0}};
        end else begin
          w_main_d = r_main_d;
        end
      end
      default: begin
        w_main_v = 1'b0;
        w_skid_v = 1'b0;
        w_main_d = {W{1'b0}};
        w_skid_d = {W{1'b0}};
      end
    endcase
  end

  // Register both entries and the upstream ready; reset discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_main_d   <= {W{1'b0}};
      r_skid_d   <= {W{1'b0}};
      r_in_ready <= 1'b1;
    end else begin
      r_main_v   <= w_main_v;
      r_skid_v   <= w_skid_v;
      r_main_d   <= w_main_d;
      r_skid_d   <= w_skid_d;
      r_in_ready <= ~w_skid_v;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;

endmodule

// File: rtl/addersub_wb_stage.sv
// addersub_wb_stage: forms the register-file write value/enable from the
// add/sub/slt unit result and holds it in a two-entry skid buffer.
// Optional feature macro: ADDERSUB_OVF_TRAP_EN (signed-overflow trap that
// raises out_ovf and suppresses out_we).
module addersub_wb_stage
  import addersub_wb_stage_pkg::*;
  #(
    parameter int WIDTH = WB_WIDTH,
    parameter int REGW  = WB_REGW
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_slt,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic [REGW-1:0]  in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [REGW-1:0]  out_dst,
    output logic             out_we,
    output logic             out_ovf
  );

`ifdef ADDERSUB_OVF_TRAP_EN
  localparam int PW = WIDTH + REGW + 2;
`else
  localparam int PW = WIDTH + REGW + 1;
`endif

  wb_entry_t         w_entry;
  logic              w_ovf;
  logic [PW-1:0]     w_in_payload;
  logic [PW-1:0]     w_out_payload;

`ifdef ADDERSUB_OVF_TRAP_EN
  assign w_ovf = add_sub_ovf(in_op, in_a_msb, in_b_msb, in_result[WIDTH-1]);
`else
  logic w_unused_s;
  assign w_ovf      = 1'b0;
  assign w_unused_s = ^{in_a_msb, in_b_msb, in_op[1:0], w_entry.ovf};
`endif

  // Build the entry: slt ops write the zero-extended less-than flag.
  always_comb begin
    w_entry = '0;
    if (in_op[IS_SLT]) begin
      w_entry.data = {{(WIDTH-1){1'b0}}, in_slt};
    end else begin
      w_entry.data = in_result;
    end
    w_entry.dst = in_dst;
    w_entry.we  = (in_dst != {REGW{1'b0}}) & ~w_ovf;
    w_entry.ovf = w_ovf;
  end

`ifdef ADDERSUB_OVF_TRAP_EN
  assign w_in_payload = w_entry;
`else
  assign w_in_payload = {w_entry.data, w_entry.dst, w_entry.we};
`endif

  addersub_wb_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  assign out_data = w_out_payload[PW-1 -: WIDTH];
  assign out_dst  = w_out_payload[PW-WIDTH-1 -: REGW];
  assign out_we   = w_out_payload[PW-WIDTH-REGW-1];
`ifdef ADDERSUB_OVF_TRAP_EN
  assign out_ovf  = w_out_payload[0];
`else
  assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_addersub_wb_stage.sv
// Scoreboard bench for addersub_wb_stage: the driver pushes hand-computed
// expected entries at accept, a monitor compares the head entry every cycle.
module tb_addersub_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_result;
  logic        in_slt;
  logic        in_a_msb;
  logic        in_b_msb;
  logic [4:0]  in_dst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dst;
  logic        out_we;
  logic        out_ovf;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        we;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef ADDERSUB_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  addersub_wb_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_result (in_result),
    .in_slt    (in_slt),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .in_dst    (in_dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dst   (out_dst),
    .out_we    (out_we),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the head entry each cycle; pop when it is emitted.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got data 0x%0h dst %0d with empty scoreboard", out_data, out_dst);
      end else begin
        chk(out_ready ? "emit_data" : "stall_data", out_data, sb[0].data);
        chk(out_ready ? "emit_dst"  : "stall_dst",  {27'd0, out_dst}, {27'd0, sb[0].dst});
        chk(out_ready ? "emit_we"   : "stall_we",   {31'd0, out_we},  {31'd0, sb[0].we});
        chk(out_ready ? "emit_ovf"  : "stall_ovf",  {31'd0, out_ovf}, {31'd0, sb[0].ovf});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one entry and wait (bounded) until it is accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] res, input logic slt,
                      input logic a, input logic b, input logic [4:0] dst,
                      input logic [31:0] ed, input logic ewe, input logic eovf,
                      input bit lat);
    exp_t e;
    bit   done = 1'b0;
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_slt    = slt;
    in_a_msb  = a;
    in_b_msb  = b;
    in_dst    = dst;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = ed; e.dst = dst; e.we = ewe; e.ovf = eovf;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles expected accept");
    end else if (lat) begin
      fork
        begin
          @(negedge clk);
          chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
          chk("lat_in_ready",  {31'd0, in_ready},  32'd1);
        end
      join_none
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_result = 32'd0; in_slt = 1'b0;
    in_a_msb = 1'b0; in_b_msb = 1'b0; in_dst = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_we",    {31'd0, out_we}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back flow with out_ready=1.
    send(3'd1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
    send(3'd0, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 5'd4, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1);
    send(3'd3, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_0005, 1'b1, 1'b0, 1'b1);
    // SLT writes the flag; SLTU to r0 does not write.
    send(3'd6, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    send(3'd4, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    // Signed overflow: ADD pos+pos -> negative, SUB neg-pos -> positive.
    send(3'd3, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 5'd9,  32'h8000_0000, ~OVF_EN, OVF_EN, 1'b0);
    send(3'd2, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd10, 32'h7FFF_FFFF, ~OVF_EN, OVF_EN, 1'b0);
    // ADDU with the same bits never traps.
    send(3'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 5'd14, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: three inputs while downstream stalls.
    out_ready = 1'b0;
    fork
      begin
        send(3'd1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 5'd11, 32'h0000_0011, 1'b1, 1'b0, 1'b0);
        send(3'd1, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
        send(3'd1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0000_0033, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_sb_depth",  sb.size(), 32'd2);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("bp_drained", sb.size(), 32'd0);

    // Reset while FULL: entries discarded, in_valid ignored during reset.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 5'd20, 32'h0000_00AA, 1'b1, 1'b0, 1'b0);
    send(3'd1, 32'h0000_00BB, 1'b0, 1'b0, 1'b0, 5'd21, 32'h0000_00BB, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b1; in_op = 3'd1; in_result = 32'h0000_00CC; in_dst = 5'd22;
    @(posedge clk);
    #1 sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mrst_out_data",  out_data, 32'd0);
    chk("mrst_out_dst",   {27'd0, out_dst}, 32'd0);
    chk("mrst_out_we",    {31'd0, out_we},  32'd0);
    chk("mrst_out_ovf",   {31'd0, out_ovf}, 32'd0);
    @(posedge clk);
    #1;

    // Normal operation resumes after reset.
    send(3'd3, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0042, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("final_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
